// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage with a prefetch queue.
// Issues sequential word fetches to an in-order instruction memory, buffers
// the responses in a DEPTH-entry queue and feeds decode one registered
// instruction per cycle. Redirects and flushes discard queued and in-flight
// fetches; the interrupt return PC is kept in i_reg_q.
module fetch_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR      = 32'h0000_0004,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic [31:0] pc_ex,
  input  logic        rti,
  input  logic        rsi,
  input  logic        interrupt,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction_dec,
  output logic [31:0] pc_curr_dec,
  output logic [31:0] pc_next_dec,
  output logic        dec_valid,
  output logic [31:0] i_reg_q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);
  // Stale fetches can pile up across back-to-back redirects, so the
  // discard counter is sized generously rather than to MAX_OUTSTANDING.
  localparam int unsigned DW = 16;

  // Queue storage (no reset needed: guarded by count_q)
  logic [31:0]   qpc_q   [DEPTH];
  logic [31:0]   qdata_q [DEPTH];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [31:0]   i_reg_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pcc_q, pcc_d;
  logic [31:0]   pcn_q, pcn_d;
  logic          dv_q, dv_d;

  logic          redirect, kill;
  logic [31:0]   target;
  logic          q_empty;
  logic [31:0]   head_pc, head_data;
  logic          issue;
  logic          rsp_any, rsp_drop, rsp_live;
  logic [31:0]   rsp_word;
  logic          pop, bypass, push;

  // Redirect decode, request credit check and response classification
  always_comb begin
    redirect = interrupt | rti | branch;
    kill     = redirect | flush;
    if (interrupt)  target = IRQ_VECTOR;
    else if (rti)   target = i_reg_q;
    else            target = pc_ex;

    q_empty   = (count_q == '0);
    head_pc   = qpc_q[rd_ptr_q];
    head_data = qdata_q[rd_ptr_q];

    imem_req_valid = rst_n && !redirect
                     && (SW'(outst_q) < SW'(MAX_OUTSTANDING))
                     && ((SW'(count_q) + SW'(outst_q)) < SW'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    issue          = imem_req_valid && imem_req_ready;

    // A response with nothing in flight (e.g. left over from before a
    // reset) is ignored entirely.
    rsp_any  = imem_rsp_valid && ((outst_q != '0) || (disc_q != '0));
    rsp_drop = rsp_any && (disc_q != '0);
    rsp_live = rsp_any && (disc_q == '0);
    rsp_word = ((imem_rsp_data == '0) || $isunknown(imem_rsp_data)) ? NOP_INSTR : imem_rsp_data;

    pop    = !kill && !stall && !q_empty;
    bypass = !kill && !stall && q_empty && rsp_live;
    push   = !kill && rsp_live && !bypass;
  end

  // PC, queue pointer and in-flight bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    disc_d     = disc_q;

    if (redirect)   fetch_pc_d = target;
    else if (issue) fetch_pc_d = fetch_pc_q + 32'd4;

    if (kill) begin
      // Every fetch still in flight becomes stale; only a request issued
      // during a flush is real. rsp_pc therefore restarts at the first
      // address fetched after this edge.
      rsp_pc_d = redirect ? target : fetch_pc_q;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      outst_d  = OW'(issue);
      disc_d   = disc_q + DW'(outst_q) - DW'(rsp_any);
    end else begin
      if (rsp_live) rsp_pc_d = rsp_pc_q + 32'd4;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
      outst_d  = outst_q + OW'(issue) - OW'(rsp_live);
      disc_d   = disc_q - DW'(rsp_drop);
    end
  end

  // Decode register and interrupt return PC
  always_comb begin
    instr_d = instr_q;
    pcc_d   = pcc_q;
    pcn_d   = pcn_q;
    dv_d    = dv_q;
    i_reg_d = i_reg_q;

    if (kill || (!stall && q_empty && !rsp_live)) begin
      instr_d = NOP_INSTR;
      pcc_d   = '0;
      pcn_d   = '0;
      dv_d    = 1'b0;
    end else if (pop) begin
      instr_d = head_data;
      pcc_d   = head_pc;
      pcn_d   = head_pc + 32'd4;
      dv_d    = 1'b1;
    end else if (bypass) begin
      instr_d = rsp_word;
      pcc_d   = rsp_pc_q;
      pcn_d   = rsp_pc_q + 32'd4;
      dv_d    = 1'b1;
    end

    if (rsi) begin
      i_reg_d = '0;
    end else if (interrupt) begin
      if (branch)        i_reg_d = pc_ex;
      else if (dv_q)     i_reg_d = pcc_q;
      else if (!q_empty) i_reg_d = head_pc;
      else               i_reg_d = fetch_pc_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      i_reg_q    <= '0;
      instr_q    <= NOP_INSTR;
      pcc_q      <= '0;
      pcn_q      <= '0;
      dv_q       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      i_reg_q    <= i_reg_d;
      instr_q    <= instr_d;
      pcc_q      <= pcc_d;
      pcn_q      <= pcn_d;
      dv_q       <= dv_d;
    end
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_ptr_q]   <= rsp_pc_q;
      qdata_q[wr_ptr_q] <= rsp_word;
    end
  end

  assign instruction_dec = instr_q;
  assign pc_curr_dec     = pcc_q;
  assign pc_next_dec     = pcn_q;
  assign dec_valid       = dv_q;

endmodule
